// File: rtl/acc_reg_file.sv
// Accumulator (res) plus a general register file, with a single memory-load port.
// A load parks the FSM in WAIT until mem_valid arrives or the TIMEOUT budget runs out.
module acc_reg_file #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] reg_sel,
  input  logic                     res_we,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     reg_we,
  input  logic                     mem_req,
  input  logic                     mem_valid,
  input  logic [WIDTH-1:0]         mem_data,
  output logic [WIDTH-1:0]         res_val,
  output logic [WIDTH-1:0]         reg_val,
  output logic                     res_zero,
  output logic                     res_neg,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err
);
  localparam int SEL_W = $clog2(NREGS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                       state, state_nx;
  logic [7:0]                   cnt, cnt_nx;
  logic [WIDTH-1:0]             res;
  logic [NREGS-1:0][WIDTH-1:0]  regs;
  logic                         res_ld_alu, res_ld_mem, reg_wr, done_nx, err_set;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    res_ld_alu = 1'b0;
    res_ld_mem = 1'b0;
    reg_wr     = 1'b0;
    done_nx    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        res_ld_alu = res_we;
        reg_wr     = reg_we;
        if (mem_req) begin
          state_nx = WAIT;
          cnt_nx   = 8'd0;
        end
      end
      WAIT: begin
        // valid is checked first so it wins on the final budgeted cycle
        if (mem_valid) begin
          res_ld_mem = 1'b1;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt_nx == 8'(TIMEOUT)) begin
            err_set  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      res       <= '0;
      regs      <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      load_done <= done_nx;
      if (err_set)         load_err <= 1'b1;
      if (res_ld_alu)      res <= alu_data;
      else if (res_ld_mem) res <= mem_data;
      // reads the pre-edge res, so a coincident res_we does not leak through
      if (reg_wr)          regs[reg_sel] <= res;
    end
  end

  assign res_val  = res;
  assign reg_val  = regs[reg_sel];
  assign res_zero = (res == '0);
  assign res_neg  = res[WIDTH-1];
  assign busy     = (state == WAIT);

  logic unused_sel_w;
  assign unused_sel_w = ^SEL_W;
endmodule

// File: tb/tb_acc_reg_file.sv
// Scoreboard bench: each stimulus cycle queues the expected post-edge outputs;
// a monitor pops one entry per rising edge and compares against the selected instance.
module tb_acc_reg_file;
  logic        clk = 1'b0;
  logic        reset, res_we, reg_we, mem_req, mem_valid;
  logic [3:0]  rsel;
  logic [31:0] alu, mdata;

  logic [15:0] a_res, a_reg;
  logic        a_zero, a_neg, a_busy, a_done, a_err;
  logic [31:0] b_res, b_reg;
  logic        b_zero, b_neg, b_busy, b_done, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_reg_file dut_a (
    .clk(clk), .reset(reset), .reg_sel(rsel[2:0]), .res_we(res_we), .alu_data(alu[15:0]),
    .reg_we(reg_we), .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mdata[15:0]),
    .res_val(a_res), .reg_val(a_reg), .res_zero(a_zero), .res_neg(a_neg),
    .busy(a_busy), .load_done(a_done), .load_err(a_err)
  );

  acc_reg_file #(.WIDTH(32), .NREGS(16), .TIMEOUT(15)) dut_b (
    .clk(clk), .reset(reset), .reg_sel(rsel), .res_we(res_we), .alu_data(alu),
    .reg_we(reg_we), .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mdata),
    .res_val(b_res), .reg_val(b_reg), .res_zero(b_zero), .res_neg(b_neg),
    .busy(b_busy), .load_done(b_done), .load_err(b_err)
  );

  typedef struct {
    string       name;
    bit          b;
    logic [31:0] res, regv;
    logic        zero, neg, busy, done, err;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(string name, bit b, logic [31:0] res, logic [31:0] regv,
                              logic busy, logic done, logic err);
    exp_t e;
    e.name = name; e.b = b; e.res = res; e.regv = regv;
    e.zero = (res == 32'd0);
    e.neg  = b ? res[31] : res[15];
    e.busy = busy; e.done = done; e.err = err;
    return e;
  endfunction

  function automatic logic [31:0] val(int i);
    return {8'(i) ^ 8'hA5, 8'hDE, 8'(i), 8'h3C};
  endfunction

  // queue the expectation, let one edge pass, then return inputs to idle
  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    reset = 0; res_we = 0; reg_we = 0; mem_req = 0; mem_valid = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [31:0] r, g;
      logic z, n, bs, d, er;
      e = q.pop_front();
      if (e.b) begin
        r = b_res; g = b_reg; z = b_zero; n = b_neg; bs = b_busy; d = b_done; er = b_err;
      end else begin
        r = {16'd0, a_res}; g = {16'd0, a_reg};
        z = a_zero; n = a_neg; bs = a_busy; d = a_done; er = a_err;
      end
      checks++;
      if (r !== e.res || g !== e.regv || z !== e.zero || n !== e.neg ||
          bs !== e.busy || d !== e.done || er !== e.err) begin
        errors++;
        $display("FAIL %s: got res=%h reg=%h z=%b n=%b busy=%b done=%b err=%b, want res=%h reg=%h z=%b n=%b busy=%b done=%b err=%b",
                 e.name, r, g, z, n, bs, d, er, e.res, e.regv, e.zero, e.neg, e.busy, e.done, e.err);
      end
    end
  end

  initial begin
    reset = 0; res_we = 0; reg_we = 0; mem_req = 0; mem_valid = 0;
    rsel = 0; alu = 0; mdata = 0;
    @(negedge clk);

    reset = 1; cyc(mk("reset", 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      rsel = 4'(i); cyc(mk("reset_regs", 0, 0, 0, 0, 0, 0));
    end

    res_we = 1; alu = 32'h8001; cyc(mk("res_we_neg", 0, 32'h8001, 0, 0, 0, 0));
    res_we = 1; alu = 32'h0; reg_we = 1; rsel = 5;
    cyc(mk("reg_we_old_res", 0, 0, 32'h8001, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      rsel = 4'(i); cyc(mk("reg_read", 0, 0, (i == 5) ? 32'h8001 : 32'h0, 0, 0, 0));
    end
    rsel = 5;

    mem_valid = 1; mdata = 32'hFFFF; cyc(mk("idle_valid_ignored", 0, 0, 32'h8001, 0, 0, 0));

    mem_req = 1; cyc(mk("load_req", 0, 0, 32'h8001, 1, 0, 0));
    repeat (3) cyc(mk("load_wait", 0, 0, 32'h8001, 1, 0, 0));
    mem_valid = 1; mdata = 32'h1234; cyc(mk("load_done", 0, 32'h1234, 32'h8001, 0, 1, 0));
    cyc(mk("load_done_pulse", 0, 32'h1234, 32'h8001, 0, 0, 0));

    mem_req = 1; res_we = 1; alu = 32'h0042;
    cyc(mk("req_with_res_we", 0, 32'h0042, 32'h8001, 1, 0, 0));
    for (int i = 1; i < 15; i++) begin
      res_we = 1; alu = 32'h7777; reg_we = 1; mem_req = 1;
      cyc(mk("wait_ignores_writes", 0, 32'h0042, 32'h8001, 1, 0, 0));
    end
    res_we = 1; alu = 32'h7777; reg_we = 1;
    cyc(mk("timeout", 0, 32'h0042, 32'h8001, 0, 0, 1));
    cyc(mk("timeout_idle", 0, 32'h0042, 32'h8001, 0, 0, 1));

    mem_req = 1; cyc(mk("sticky_req", 0, 32'h0042, 32'h8001, 1, 0, 1));
    mem_valid = 1; mdata = 32'h00FF; cyc(mk("first_cycle_valid", 0, 32'h00FF, 32'h8001, 0, 1, 1));

    mem_req = 1; cyc(mk("edge_req", 0, 32'h00FF, 32'h8001, 1, 0, 1));
    repeat (14) cyc(mk("edge_wait", 0, 32'h00FF, 32'h8001, 1, 0, 1));
    mem_valid = 1; mdata = 32'hA5A5; cyc(mk("valid_at_timeout", 0, 32'hA5A5, 32'h8001, 0, 1, 1));

    mem_req = 1; cyc(mk("rst_req", 0, 32'hA5A5, 32'h8001, 1, 0, 1));
    cyc(mk("rst_wait", 0, 32'hA5A5, 32'h8001, 1, 0, 1));
    reset = 1; mem_valid = 1; mdata = 32'h5555; cyc(mk("reset_mid_load", 0, 0, 0, 0, 0, 0));
    cyc(mk("reset_mid_load_after", 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      rsel = 4'(i); res_we = 1; alu = val(i); cyc(mk("wide_res_we", 1, val(i), 0, 0, 0, 0));
      reg_we = 1; cyc(mk("wide_reg_we", 1, val(i), val(i), 0, 0, 0));
    end
    for (int i = 0; i < 16; i++) begin
      rsel = 4'(i); cyc(mk("wide_readback", 1, val(15), val(i), 0, 0, 0));
    end

    @(posedge clk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
